// File: rtl/sha256_msg_schedule_if.sv
// Handshake bundle between the SHA-256 message loader, the schedule stage and
// the compression datapath word registers.
interface sha256_msg_schedule_if;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_ready;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_o;
  logic [5:0]  w_index;
  logic        done;

  modport master (
    output in_valid, in_word, w_ready,
    input  in_ready, w_valid, w_o, w_index, done
  );

  modport slave (
    input  in_valid, in_word, w_ready,
    output in_ready, w_valid, w_o, w_index, done
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 message words into a sliding window and
// streams W[0..63], one word per cycle, using a single sigma0/sigma1 adder tree.
module sha256_msg_schedule (
  input  logic                        CLK,
  input  logic                        RST,
  sha256_msg_schedule_if.slave        bus
);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  t_q, t_d;
  logic        done_q, done_d;

  logic        accept;
  logic        consume;
  logic [31:0] w_next;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign accept  = (state_q == LOAD) && bus.in_valid;
  assign consume = (state_q == RUN) && bus.w_ready;

  // win[14], win[9], win[1], win[0] hold W[t+14], W[t+9], W[t+1], W[t].
  assign w_next = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    done_d  = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      win_d[i] = win_q[i];
    end

    if (accept || consume) begin
      for (int unsigned i = 0; i < 15; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[15] = accept ? bus.in_word : w_next;
    end

    if (accept) begin
      if (cnt_q == 4'd15) begin
        state_d = RUN;
        cnt_d   = '0;
        t_d     = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    if (consume) begin
      if (t_q == 6'd63) begin
        state_d = LOAD;
        t_d     = '0;
        done_d  = 1'b1;
      end else begin
        t_d = t_q + 6'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      t_q     <= '0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      done_q  <= done_d;
      for (int unsigned i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign bus.in_ready = (state_q == LOAD);
  assign bus.w_valid  = (state_q == RUN);
  assign bus.w_o      = (state_q == RUN) ? win_q[0] : '0;
  assign bus.w_index  = t_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: "abc" and zero blocks, backpressure,
// input gaps, asynchronous reset mid-run and back-to-back blocks.
module tb_sha256_msg_schedule;

  logic CLK;
  logic RST;
  int   tests;
  int   fails;

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];

  sha256_msg_schedule_if ifc ();

  sha256_msg_schedule dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic compute_ref();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = blk[t];
      else exp_w[t] = ss1(exp_w[t-2]) + exp_w[t-7] + ss0(exp_w[t-15]) + exp_w[t-16];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(ifc.in_ready), 32'd1);
    check({tag, "_w_valid"},  32'(ifc.w_valid),  32'd0);
    check({tag, "_w_o"},      ifc.w_o,           32'd0);
    check({tag, "_w_index"},  32'(ifc.w_index),  32'd0);
    check({tag, "_done"},     32'(ifc.done),     32'd0);
  endtask

  // Called at a negedge; returns at the negedge where w_valid should be up.
  task automatic load_block(input bit gaps);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < 16 && guard < 200) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        ifc.in_valid = 1'b0;
      end else begin
        ifc.in_valid = 1'b1;
        ifc.in_word  = blk[i];
        if (ifc.in_ready) i++;
      end
      @(negedge CLK);
      guard++;
      if (i < 16) check("load_done_low", 32'(ifc.done), 32'd0);
    end
    ifc.in_valid = 1'b0;
    check("load_count", 32'(i), 32'd16);
    check("load_w_valid", 32'(ifc.w_valid), 32'd1);
    check("load_w0_first", ifc.w_o, blk[0]);
  endtask

  // Called at the negedge where w_valid is high with t=0.
  task automatic run_block(input int stop_at, input bit stall, input bit offer, input bit chk_abc);
    if (offer) begin
      ifc.in_valid = 1'b1;
      ifc.in_word  = 32'hDEADBEEF;
    end
    for (int k = 0; k < 64; k++) begin
      if (k == stop_at) begin
        ifc.w_ready = 1'b0;
        return;
      end
      if (stall && k == 30) begin
        ifc.w_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge CLK);
          check("stall_w_o",     ifc.w_o,          exp_w[30]);
          check("stall_w_index", 32'(ifc.w_index), 32'd30);
          check("stall_w_valid", 32'(ifc.w_valid), 32'd1);
        end
      end
      check("run_w_valid", 32'(ifc.w_valid), 32'd1);
      check("run_w_o",     ifc.w_o,          exp_w[k]);
      check("run_w_index", 32'(ifc.w_index), 32'(k));
      check("run_done",    32'(ifc.done),    32'd0);
      if (offer) check("run_in_ready", 32'(ifc.in_ready), 32'd0);
      if (chk_abc) begin
        if (k == 0)  check("abc_w0",  ifc.w_o, 32'h61626380);
        if (k == 15) check("abc_w15", ifc.w_o, 32'h00000018);
        if (k == 16) check("abc_w16", ifc.w_o, 32'h61626380);
        if (k == 17) check("abc_w17", ifc.w_o, 32'h000F0000);
      end
      ifc.w_ready = 1'b1;
      @(negedge CLK);
    end
    ifc.w_ready = 1'b0;
    check("end_done",     32'(ifc.done),     32'd1);
    check("end_in_ready", 32'(ifc.in_ready), 32'd1);
    check("end_w_valid",  32'(ifc.w_valid),  32'd0);
    check("end_w_index",  32'(ifc.w_index),  32'd0);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    compute_ref();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RST = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_word  = '0;
    ifc.w_ready  = 1'b0;

    repeat (2) @(negedge CLK);
    check_reset_outputs("por");
    RST = 1'b0;
    @(negedge CLK);

    // "abc" block with w_ready held high
    set_abc();
    load_block(1'b0);
    run_block(64, 1'b0, 1'b0, 1'b1);

    // All-zero block straight after done
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    compute_ref();
    load_block(1'b0);
    run_block(64, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset at t=20
    set_abc();
    load_block(1'b0);
    run_block(20, 1'b0, 1'b0, 1'b0);
    check("pre_reset_index", 32'(ifc.w_index), 32'd20);
    #1 RST = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge CLK);
    RST = 1'b0;

    // Gapped load, stall at t=30, second block offered during RUN
    load_block(1'b1);
    run_block(64, 1'b1, 1'b1, 1'b1);

    // Back-to-back arbitrary block
    for (int i = 0; i < 16; i++) blk[i] = $urandom();
    compute_ref();
    load_block(1'b0);
    run_block(64, 1'b0, 1'b0, 1'b0);

    @(negedge CLK);
    check("final_done_low", 32'(ifc.done), 32'd0);
    check("final_in_ready", 32'(ifc.in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
